// File: rtl/sn_pkg.sv
// Shared types and defaults for the stochastic-number stream decoder.
package sn_pkg;

    localparam int unsigned SN_WIN_LOG2_DEF = 8;
    localparam int unsigned SN_OUT_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sn_state_e;

    // Offset subtracted from the scaled count in bipolar mode: 2^(out_w-1).
    function automatic int unsigned sn_bip_offset(input int unsigned out_w);
        return 32'd1 << (out_w - 1);
    endfunction

endpackage

// File: rtl/sn_scale_sat.sv
// Combinational scaler: window ones count + encoding mode -> saturated result.
module sn_scale_sat
    import sn_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = SN_WIN_LOG2_DEF,
    parameter int unsigned OUT_W    = SN_OUT_W_DEF
) (
    input  logic [WIN_LOG2:0] ones,
    input  logic              bipolar,
    output logic [OUT_W-1:0]  value,
    output logic              sat
);

    localparam int unsigned      SHIFT      = WIN_LOG2 - OUT_W;
    localparam logic [OUT_W-1:0] BIP_OFFSET = OUT_W'(sn_bip_offset(OUT_W));
    localparam logic [OUT_W-1:0] BIP_MAX    = ~BIP_OFFSET;

    // ones never exceeds 2^WIN_LOG2, so its top OUT_W+1 bits are the truncated scale.
    logic [OUT_W:0] scaled;
    assign scaled = ones[WIN_LOG2 -: OUT_W+1];

    // Low bits fall below the output resolution and are truncated away.
    if (SHIFT > 0) begin : g_trunc
        logic unused_low;
        assign unused_low = ^ones[SHIFT-1:0];
    end

    // Full scale (scaled == 2^OUT_W) is the only value that can clip in either mode.
    always_comb begin
        value = '0;
        sat   = 1'b0;
        if (scaled[OUT_W]) begin
            sat   = 1'b1;
            value = bipolar ? BIP_MAX : {OUT_W{1'b1}};
        end else begin
            value = bipolar ? (scaled[OUT_W-1:0] - BIP_OFFSET) : scaled[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/sn_stream_decoder.sv
// Stochastic bitstream decoder: counts ones over a 2^WIN_LOG2 valid-bit window
// and presents a registered, saturated result through a valid/ready handshake.
module sn_stream_decoder
    import sn_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = SN_WIN_LOG2_DEF,
    parameter int unsigned OUT_W    = SN_OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bipolar,
    input  logic              sn_valid,
    input  logic              sn_bit,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_value,
    output logic              res_sat,
    output logic [WIN_LOG2:0] res_count,
    output logic              dropped
);

    sn_state_e         state_q, state_d;
    logic [WIN_LOG2:0] ones_q, ones_d;
    logic [WIN_LOG2-1:0] idx_q, idx_d;
    logic              bipolar_q, bipolar_d;
    logic [OUT_W-1:0]  value_q, value_d;
    logic              sat_q, sat_d;
    logic [WIN_LOG2:0] count_q, count_d;
    logic              dropped_q, dropped_d;

    logic [WIN_LOG2:0] ones_inc;
    logic [OUT_W-1:0]  scale_value;
    logic              scale_sat;

    assign ones_inc = ones_q + {{WIN_LOG2{1'b0}}, sn_bit};

    // Scaling sees the count including the current bit so the last bit lands in the result.
    sn_scale_sat #(
        .WIN_LOG2 (WIN_LOG2),
        .OUT_W    (OUT_W)
    ) u_scale (
        .ones    (ones_inc),
        .bipolar (bipolar_q),
        .value   (scale_value),
        .sat     (scale_sat)
    );

    // State, counters and result registers; reset discards any partial window.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            ones_q    <= '0;
            idx_q     <= '0;
            bipolar_q <= 1'b0;
            value_q   <= '0;
            sat_q     <= 1'b0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            idx_q     <= idx_d;
            bipolar_q <= bipolar_d;
            value_q   <= value_d;
            sat_q     <= sat_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    // Next-state: start (re)opens a window from IDLE or ACCUM; the last valid bit loads the result.
    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        idx_d     = idx_q;
        bipolar_d = bipolar_q;
        value_d   = value_q;
        sat_d     = sat_q;
        count_d   = count_q;
        dropped_d = dropped_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    ones_d    = '0;
                    idx_d     = '0;
                    bipolar_d = bipolar;
                    dropped_d = 1'b0;
                end else if (sn_valid) begin
                    dropped_d = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    ones_d    = '0;
                    idx_d     = '0;
                    bipolar_d = bipolar;
                    dropped_d = 1'b0;
                end else if (sn_valid) begin
                    ones_d = ones_inc;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == {WIN_LOG2{1'b1}}) begin
                        state_d = HOLD;
                        value_d = scale_value;
                        sat_d   = scale_sat;
                        count_d = ones_inc;
                    end
                end
            end
            HOLD: begin
                if (sn_valid) begin
                    dropped_d = 1'b1;
                end
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ACCUM);
    assign res_valid = (state_q == HOLD);
    assign res_value = value_q;
    assign res_sat   = sat_q;
    assign res_count = count_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_sn_stream_decoder.sv
// Self-checking bench for sn_stream_decoder: table-driven windows, corner-case
// sequences and a randomized run against a window-level reference model.
module tb_sn_stream_decoder;

    localparam int WIN   = 8;
    localparam int OUTW  = 4;
    localparam int NBITS = 1 << WIN;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, bipolar, sn_valid, sn_bit, res_ready;
    logic             busy, res_valid, res_sat, dropped;
    logic [OUTW-1:0]  res_value;
    logic [WIN:0]     res_count;

    int errors = 0;
    int checks = 0;

    // Reference model: window-level view of the decoder.
    int m_collect, m_pending, m_drop, m_bip, m_bits, m_ones;
    int m_val, m_sat, m_cnt;

    typedef struct {
        int bip;
        int alt;
        int ones;
        int cnt;
        int val;
        int sat;
    } vec_t;

    vec_t tbl[9];

    sn_stream_decoder #(
        .WIN_LOG2 (WIN),
        .OUT_W    (OUTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bipolar   (bipolar),
        .sn_valid  (sn_valid),
        .sn_bit    (sn_bit),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_value (res_value),
        .res_sat   (res_sat),
        .res_count (res_count),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_collect = 0; m_pending = 0; m_drop = 0; m_bip = 0;
        m_bits = 0; m_ones = 0; m_val = 0; m_sat = 0; m_cnt = 0;
    endtask

    // Result of a completed window, from the arithmetic definition.
    task automatic model_result(input int ones, input int bip);
        int scaled, v;
        scaled = ones / (1 << (WIN - OUTW));
        if (bip == 0) begin
            m_sat = (scaled > (1 << OUTW) - 1) ? 1 : 0;
            m_val = (m_sat != 0) ? (1 << OUTW) - 1 : scaled;
        end else begin
            v = scaled - (1 << (OUTW - 1));
            m_sat = (v > (1 << (OUTW - 1)) - 1) ? 1 : 0;
            if (m_sat != 0) v = (1 << (OUTW - 1)) - 1;
            m_val = v & ((1 << OUTW) - 1);
        end
        m_cnt = ones;
    endtask

    task automatic model_step(input int s, input int b, input int v, input int d, input int r);
        if (m_pending != 0) begin
            if (v != 0) m_drop = 1;
            if (r != 0) m_pending = 0;
        end else if (s != 0) begin
            m_collect = 1; m_bits = 0; m_ones = 0; m_bip = b; m_drop = 0;
        end else if (m_collect != 0) begin
            if (v != 0) begin
                m_bits++;
                m_ones += d;
                if (m_bits == NBITS) begin
                    m_collect = 0;
                    m_pending = 1;
                    model_result(m_ones, m_bip);
                end
            end
        end else if (v != 0) begin
            m_drop = 1;
        end
    endtask

    task automatic compare_all();
        chk("busy",      int'(busy),      m_collect);
        chk("res_valid", int'(res_valid), m_pending);
        chk("dropped",   int'(dropped),   m_drop);
        chk("res_value", int'(res_value), m_val);
        chk("res_sat",   int'(res_sat),   m_sat);
        chk("res_count", int'(res_count), m_cnt);
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic cyc(input int s, input int b, input int v, input int d, input int r);
        start     = (s != 0);
        bipolar   = (b != 0);
        sn_valid  = (v != 0);
        sn_bit    = (d != 0);
        res_ready = (r != 0);
        @(posedge clk);
        model_step(s, b, v, d, r);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        start = 1'b0; bipolar = 1'b0; sn_valid = 1'b0; sn_bit = 1'b0; res_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_async_busy",  int'(busy),      0);
        chk("rst_async_count", int'(res_count), 0);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b0;
    endtask

    task automatic run_window(input vec_t t);
        cyc(1, t.bip, 0, 0, 0);
        for (int k = 0; k < NBITS; k++) begin
            if (t.alt != 0) begin
                cyc(0, 1 - t.bip, 0, 1, 0);
                cyc(0, 1 - t.bip, 1, (k % 2 == 0) ? 1 : 0, 0);
            end else begin
                cyc(0, 1 - t.bip, 1, (k < t.ones) ? 1 : 0, 0);
            end
        end
        chk("tbl_res_valid", int'(res_valid), 1);
        chk("tbl_res_count", int'(res_count), t.cnt);
        chk("tbl_res_value", int'(res_value), t.val);
        chk("tbl_res_sat",   int'(res_sat),   t.sat);
        cyc(0, 0, 0, 0, 1);
        chk("tbl_release", int'(res_valid), 0);
    endtask

    initial begin
        tbl[0] = '{bip: 0, alt: 0, ones: 256, cnt: 256, val: 15, sat: 1};
        tbl[1] = '{bip: 1, alt: 0, ones: 0,   cnt: 0,   val: 8,  sat: 0};
        tbl[2] = '{bip: 1, alt: 0, ones: 256, cnt: 256, val: 7,  sat: 1};
        tbl[3] = '{bip: 0, alt: 1, ones: 0,   cnt: 128, val: 8,  sat: 0};
        tbl[4] = '{bip: 1, alt: 1, ones: 0,   cnt: 128, val: 0,  sat: 0};
        tbl[5] = '{bip: 0, alt: 0, ones: 255, cnt: 255, val: 15, sat: 0};
        tbl[6] = '{bip: 1, alt: 0, ones: 255, cnt: 255, val: 7,  sat: 0};
        tbl[7] = '{bip: 1, alt: 0, ones: 16,  cnt: 16,  val: 9,  sat: 0};
        tbl[8] = '{bip: 0, alt: 0, ones: 15,  cnt: 15,  val: 0,  sat: 0};

        rst_n = 1'b1;
        start = 1'b0; bipolar = 1'b0; sn_valid = 1'b0; sn_bit = 1'b0; res_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) run_window(tbl[i]);

        // HOLD stall: result stable, start ignored, stray bits set dropped.
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < NBITS; k++) cyc(0, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) cyc((i == 5) ? 1 : 0, 1, 1, 1, 0);
        chk("stall_dropped", int'(dropped),   1);
        chk("stall_valid",   int'(res_valid), 1);
        chk("stall_count",   int'(res_count), 256);
        chk("stall_busy",    int'(busy),      0);
        cyc(0, 0, 0, 0, 1);
        chk("stall_idle", int'(res_valid), 0);
        cyc(1, 0, 0, 0, 0);
        chk("start_clears_dropped", int'(dropped), 0);

        // Restart after 100 ones discards them.
        for (int k = 0; k < 100; k++) cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        for (int k = 0; k < NBITS; k++) cyc(0, 0, 1, 0, 0);
        chk("restart_count", int'(res_count), 0);
        chk("restart_valid", int'(res_valid), 1);
        cyc(0, 0, 0, 0, 1);

        // start coincident with the last bit: no result, window restarts unipolar.
        cyc(1, 1, 0, 0, 0);
        for (int k = 0; k < NBITS - 1; k++) cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        chk("coincide_no_valid", int'(res_valid), 0);
        chk("coincide_busy",     int'(busy),      1);
        for (int k = 0; k < NBITS; k++) cyc(0, 1, 1, 1, 0);
        chk("coincide_count", int'(res_count), 256);
        chk("coincide_value", int'(res_value), 15);
        cyc(0, 0, 0, 0, 1);

        // Reset mid-window, then bits before start only set dropped.
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 50; k++) cyc(0, 0, 1, 1, 0);
        apply_reset();
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1, 0);
        chk("post_rst_dropped", int'(dropped),   1);
        chk("post_rst_busy",    int'(busy),      0);
        chk("post_rst_valid",   int'(res_valid), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            int s;
            if (m_collect == 0 && m_pending == 0)
                s = ($urandom_range(0, 9) == 0) ? 1 : 0;
            else
                s = ($urandom_range(0, 599) == 0) ? 1 : 0;
            cyc(s, int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0,
                int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sn_stream_decoder.md
Name: sn_stream_decoder

Overview:
- Converts an incoming serial stochastic-number (SN) bitstream into a binary value by counting ones over a fixed window of 2^WIN_LOG2 valid bits.
- Supports unipolar and bipolar encodings; delivers a registered, saturated OUT_W-bit result through a valid/ready handshake.
- Sits at the receive end of the SN datapath, downstream of the comparator/LFSR encoders and the XNOR/AND stochastic arithmetic stages.
- Replaces the ad hoc up-counter averaging with a controlled, restartable decoder.

Parameters:
- WIN_LOG2, 8, log2 of window length in valid bits (window = 256 bits); must be >= OUT_W.
- OUT_W, 4, result width; unsigned in unipolar mode, two's-complement in bipolar mode.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1) despite its name.
- start  input  1  single-cycle pulse; begins a new window.
- bipolar  input  1  encoding select; sampled only on accepted start.
- sn_valid  input  1  qualifies sn_bit this cycle.
- sn_bit  input  1  stochastic stream bit.
- busy  output  1  high in ACCUM.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_value  output  OUT_W  decoded value.
- res_sat  output  1  result was saturated.
- res_count  output  WIN_LOG2+1  raw ones count of the window.
- dropped  output  1  sticky: valid bits arrived while not in ACCUM.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0; mode 0. Reset mid-window discards the partial count.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 -> ACCUM next cycle; ones count and bit index cleared; bipolar latched; dropped cleared.
  - sn_valid=1 without start sets dropped.
- ACCUM:
  - Each cycle with sn_valid=1: ones += sn_bit; idx += 1. Cycles with sn_valid=0 hold state (gaps allowed).
  - On the valid bit where idx == 2^WIN_LOG2-1, that bit is counted, the result registers are loaded, and the FSM goes to HOLD.
  - res_valid rises the cycle after the last valid bit (latency 1).
  - start=1 in ACCUM restarts the window: counters cleared, bipolar relatched, the bit that cycle discarded. This also applies when start coincides with the last bit.
- HOLD:
  - res_valid=1; res_value, res_sat and res_count stable until handshake.
  - res_valid & res_ready -> IDLE next cycle, res_valid drops.
  - start is ignored in HOLD. sn_valid sets dropped and the bit is discarded.
- Arithmetic:
  - ones counter is WIN_LOG2+1 bits; range 0..2^WIN_LOG2; never wraps.
  - scaled = ones >> (WIN_LOG2-OUT_W); range 0..2^OUT_W.
  - Unipolar: res_value = min(scaled, 2^OUT_W-1); res_sat=1 iff scaled == 2^OUT_W.
  - Bipolar: v = scaled - 2^(OUT_W-1), signed; clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; res_sat=1 iff clamped. Only the upper bound can clip.
  - Truncation, no rounding.
- dropped clears only on an accepted start or reset.

Decomposition:
- Package sn_pkg: state enum (IDLE/ACCUM/HOLD); default WIN_LOG2/OUT_W constants; bipolar offset constant helper.
- Sub-module sn_scale_sat (combinational): ones count + mode -> res_value, res_sat. Unit-testable exhaustively.
- FSM, counters and result registers stay in sn_stream_decoder.

Test Plan:
- Start unipolar, 256 consecutive valid 1s -> res_valid at last-bit+1; res_count=256, res_value=15, res_sat=1.
- Start bipolar, 256 valid 0s -> res_count=0, res_value=4'b1000 (-8), res_sat=0. Same with all 1s -> res_value=7, res_sat=1.
- Alternating 1010 pattern, 256 bits, sn_valid toggled 50% duty -> res_count=128. Unipolar res_value=8; bipolar res_value=0. Window spans 512 cycles.
- res_ready held low 20 cycles in HOLD while sn_valid=1 -> outputs stable, dropped=1, no new window. res_ready=1 -> IDLE next cycle. Next start clears dropped.
- start pulsed after 100 valid 1s, then 256 valid 0s -> res_count=0 (restart discarded the first 100). start coincident with the last bit -> no res_valid, window restarts.
- rst_n asserted mid-ACCUM -> asynchronously IDLE, all outputs 0. After deassert, sn bits before start only set dropped.
